// File: rtl/spread_guard.sv
// Spread breach guard: tracks consecutive |spread| breaches, halts upstream after
// BREACH_LIMIT in a row, and keeps running statistics of accepted samples.
module spread_guard #(
  parameter int BREACH_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable_count,
  input  logic        spread_valid,
  input  logic [7:0]  spread_now,
  input  logic [7:0]  threshold,
  input  logic        resume,
  output logic        halt_signal,
  output logic        warn,
  output logic [3:0]  breach_count,
  output logic [7:0]  avg_spread,
  output logic [7:0]  max_abs_spread,
  output logic [15:0] sample_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MONITOR = 2'd1;
  localparam logic [1:0] WARN    = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;
  localparam logic [3:0] LIMIT   = BREACH_LIMIT[3:0];

  logic [1:0]       state;
  logic [3:0][7:0]  win;
  logic [9:0]       sum;
  logic [8:0]       abs9;
  logic [9:0]       sum_next;
  logic [3:0]       bc_inc;
  logic             accept;
  logic             breach;

  // 9-bit magnitude so that -128 maps to 128 rather than wrapping
  assign abs9     = spread_now[7] ? (~{1'b1, spread_now} + 9'd1) : {1'b0, spread_now};
  assign breach   = abs9 > {1'b0, threshold};
  assign accept   = spread_valid && enable_count && (state == MONITOR || state == WARN);
  assign sum_next = sum + {{2{spread_now[7]}}, spread_now} - {{2{win[3][7]}}, win[3]};
  assign bc_inc   = breach_count + 4'd1;

  assign halt_signal = (state == HALT);
  assign warn        = (state == WARN);
  assign avg_spread  = sum[9:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      breach_count   <= '0;
      win            <= '0;
      sum            <= '0;
      max_abs_spread <= '0;
      sample_count   <= '0;
    end else begin
      if (accept) begin
        win          <= {win[2:0], spread_now};
        sum          <= sum_next;
        if (abs9 > {1'b0, max_abs_spread}) max_abs_spread <= abs9[7:0];
        if (sample_count != 16'hFFFF) sample_count <= sample_count + 16'd1;
      end
      case (state)
        IDLE: if (enable_count) state <= MONITOR;
        MONITOR: begin
          if (!enable_count) begin
            state        <= IDLE;
            breach_count <= '0;
          end else if (accept && breach) begin
            breach_count <= 4'd1;
            state        <= (LIMIT == 4'd1) ? HALT : WARN;
          end
        end
        WARN: begin
          if (!enable_count) begin
            state        <= IDLE;
            breach_count <= '0;
          end else if (accept && breach) begin
            breach_count <= bc_inc;
            if (bc_inc >= LIMIT) state <= HALT;
          end else if (accept) begin
            breach_count <= '0;
            state        <= MONITOR;
          end
        end
        default: begin
          // HALT is sticky; only an operator resume leaves it
          if (resume) begin
            state        <= enable_count ? MONITOR : IDLE;
            breach_count <= '0;
            win          <= '0;
            sum          <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spread_guard.sv
// Directed table-driven bench for spread_guard with hand-computed expectations,
// plus hand sequences for asynchronous reset mid-WARN.
module tb_spread_guard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable_count;
  logic        spread_valid;
  logic [7:0]  spread_now;
  logic [7:0]  threshold;
  logic        resume;
  logic        halt_signal;
  logic        warn;
  logic [3:0]  breach_count;
  logic [7:0]  avg_spread;
  logic [7:0]  max_abs_spread;
  logic [15:0] sample_count;

  int compared = 0;
  int mismatched = 0;

  spread_guard #(.BREACH_LIMIT(3)) dut (
    .clk(clk), .reset_n(reset_n), .enable_count(enable_count),
    .spread_valid(spread_valid), .spread_now(spread_now), .threshold(threshold),
    .resume(resume), .halt_signal(halt_signal), .warn(warn),
    .breach_count(breach_count), .avg_spread(avg_spread),
    .max_abs_spread(max_abs_spread), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              en;
    logic              vld;
    logic signed [7:0] sp;
    logic [7:0]        thr;
    logic              res;
    logic              e_halt;
    logic              e_warn;
    logic [3:0]        e_bc;
    logic signed [7:0] e_avg;
    logic [7:0]        e_max;
    logic [15:0]       e_cnt;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input int act, input int exp_v);
    compared++;
    if (act != exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic h, input logic w, input logic [3:0] bc,
                         input logic [7:0] av, input logic [7:0] mx, input logic [15:0] cnt);
    chk({tag, ".halt"}, int'(halt_signal), int'(h));
    chk({tag, ".warn"}, int'(warn), int'(w));
    chk({tag, ".bc"},   int'(breach_count), int'(bc));
    chk({tag, ".avg"},  int'(avg_spread), int'(av));
    chk({tag, ".max"},  int'(max_abs_spread), int'(mx));
    chk({tag, ".cnt"},  int'(sample_count), int'(cnt));
  endtask

  initial begin
    //          en vld  sp    thr  res  halt warn bc avg  max cnt
    tbl[0]  = '{1, 0,    0,   10,  0,   0,   0,  0,   0,   0,  0}; // IDLE -> MONITOR
    tbl[1]  = '{1, 1,    4,   10,  0,   0,   0,  0,   1,   4,  1};
    tbl[2]  = '{1, 1,    5,   10,  0,   0,   0,  0,   2,   5,  2};
    tbl[3]  = '{1, 1,  -12,   10,  0,   0,   1,  1,  -1,  12,  3};
    tbl[4]  = '{1, 1,    3,   10,  0,   0,   0,  0,   0,  12,  4};
    tbl[5]  = '{1, 1,   20,   10,  0,   0,   1,  1,   4,  20,  5};
    tbl[6]  = '{1, 1,  -15,   10,  0,   0,   1,  2,  -1,  20,  6};
    tbl[7]  = '{1, 1,   11,   10,  0,   1,   0,  3,   4,  20,  7}; // third breach halts
    tbl[8]  = '{1, 1,   50,   10,  0,   1,   0,  3,   4,  20,  7}; // ignored in HALT
    tbl[9]  = '{0, 0,    0,   10,  0,   1,   0,  3,   4,  20,  7}; // sticky HALT
    tbl[10] = '{1, 0,    0,   10,  1,   0,   0,  0,   0,  20,  7}; // resume -> MONITOR
    tbl[11] = '{1, 1, -128,  127,  0,   0,   1,  1, -32, 128,  8};
    tbl[12] = '{1, 1,   10,   10,  0,   0,   0,  0, -30, 128,  9}; // equal is not breach
    tbl[13] = '{1, 1,  -11,   10,  0,   0,   1,  1, -33, 128, 10};
    tbl[14] = '{0, 1,  -50,   10,  0,   0,   0,  0, -33, 128, 10}; // disable beats sample
    tbl[15] = '{0, 1,  100,   10,  0,   0,   0,  0, -33, 128, 10}; // IDLE ignores valid
    tbl[16] = '{0, 0,    0,   10,  1,   0,   0,  0, -33, 128, 10}; // resume outside HALT
    tbl[17] = '{1, 0,    0,   10,  0,   0,   0,  0, -33, 128, 10};
    tbl[18] = '{1, 0,    0,   10,  1,   0,   0,  0, -33, 128, 10}; // resume in MONITOR
    tbl[19] = '{1, 1,   50,   10,  0,   0,   1,  1, -20, 128, 11};

    reset_n = 1'b0; enable_count = 0; spread_valid = 0; spread_now = 0;
    threshold = 10; resume = 0;
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      enable_count = tbl[i].en;
      spread_valid = tbl[i].vld;
      spread_now   = tbl[i].sp;
      threshold    = tbl[i].thr;
      resume       = tbl[i].res;
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), tbl[i].e_halt, tbl[i].e_warn, tbl[i].e_bc,
              tbl[i].e_avg, tbl[i].e_max, tbl[i].e_cnt);
    end
    spread_valid = 0; resume = 0;

    // asynchronous reset while in WARN, checked before the next edge
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    enable_count = 1;
    @(posedge clk); #1;
    chk_all("post_rst_mon", 0, 0, 0, 0, 0, 0);
    spread_valid = 1; spread_now = 8'sd12; threshold = 10;
    @(posedge clk); #1;
    chk_all("post_rst_smp", 0, 1, 1, 3, 12, 1);
    spread_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/spread_guard.md
SPREAD_GUARD -- requirements
Module: spread_guard

Interface
REQ-001 The block SHALL have parameter BREACH_LIMIT, default 3, meaning consecutive breaching samples that trigger halt (legal 1-15).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port enable_count  input  1  monitoring enable.
REQ-005 The block SHALL have port spread_valid  input  1  one-cycle strobe: spread_now carries a new upstream spread sample.
REQ-006 The block SHALL have port spread_now  input  8  spread sample, two's-complement signed (buy minus sell).
REQ-007 The block SHALL have port threshold  input  8  unsigned breach threshold on |spread|.
REQ-008 The block SHALL have port resume  input  1  operator release from HALT.
REQ-009 The block SHALL have port halt_signal  output  1  high while in HALT; drives the upstream spread stage halt input.
REQ-010 The block SHALL have port warn  output  1  high while in WARN.
REQ-011 The block SHALL have port breach_count  output  4  current consecutive-breach count.
REQ-012 The block SHALL have port avg_spread  output  8  signed mean of last 4 accepted samples.
REQ-013 The block SHALL have port max_abs_spread  output  8  largest |spread| accepted since reset, unsigned.
REQ-014 The block SHALL have port sample_count  output  16  accepted samples since reset, saturating.

Function
REQ-015 FSM states SHALL be IDLE, MONITOR, WARN and HALT; halt_signal and warn SHALL be decoded from registered state only.
REQ-016 A sample SHALL be accepted only when spread_valid=1 and state is MONITOR or WARN; otherwise spread_valid is ignored with no effect on any register.
REQ-017 |spread| SHALL be computed at 9 bits, so -128 gives 128; a breach is |spread| strictly greater than threshold.
REQ-018 IDLE -> MONITOR when enable_count=1; MONITOR or WARN -> IDLE when enable_count=0, with breach_count cleared; enable_count=0 SHALL take priority over a same-cycle sample.
REQ-019 MONITOR: an accepted breach sets breach_count=1 and goes to WARN, or goes to HALT if BREACH_LIMIT=1.
REQ-020 WARN: an accepted breach increments breach_count and goes to HALT when the count reaches BREACH_LIMIT; an accepted non-breach clears breach_count and returns to MONITOR; no sample holds state.
REQ-021 halt_signal SHALL rise on the same clock edge that accepts the BREACH_LIMIT-th breach (latency 0 cycles after the accepting edge).
REQ-022 HALT SHALL be sticky: enable_count=0 does not leave it, and samples are ignored.
REQ-023 HALT: resume=1 SHALL go to MONITOR if enable_count=1, else IDLE, and SHALL clear breach_count, the average window and its sum; resume outside HALT SHALL have no effect.
REQ-024 Averaging window:
  - 4-entry shift register of accepted samples, zero-filled at reset.
  - 10-bit signed running sum updated incrementally (add new, subtract oldest).
  - avg_spread = sum arithmetic-shifted right by 2 (floor), visible after the accepting edge.
REQ-025 max_abs_spread SHALL update to |spread| when the accepted |spread| exceeds it; it is cleared only by reset.
REQ-026 sample_count SHALL increment per accepted sample and hold at 65535.

Reset
REQ-027 reset_n=0 SHALL immediately, without a clock, force state IDLE and set halt_signal, warn, breach_count, avg_spread, max_abs_spread, sample_count, the window and the sum to 0, including mid-WARN or mid-HALT.
REQ-028 Operation SHALL resume on the first rising clk edge after reset_n returns to 1.

Verification
REQ-029 Scenario 1: threshold=10, enable=1; samples 4, 5, -12, 3 -> after -12: warn=1, breach_count=1; after 3: warn=0, breach_count=0, avg_spread=0, max_abs_spread=12, sample_count=4.
REQ-030 Scenario 2: samples 20, -15, 11 -> halt_signal=1 on the edge accepting 11; a following sample 50 is ignored, with max_abs_spread=20 and sample_count unchanged.
REQ-031 Scenario 3: in HALT, drop enable_count -> halt_signal stays 1; then enable=1 and resume=1 for one cycle -> MONITOR, halt_signal=0, breach_count=0, avg_spread=0.
REQ-032 Scenario 4: threshold=127, sample -128 -> breach; threshold=10, sample 10 -> no breach; sample -11 -> breach.
REQ-033 Scenario 5: spread_valid pulses while enable_count=0 -> all outputs unchanged; enable_count=0 coinciding with a breaching sample in WARN -> IDLE, breach_count=0.
REQ-034 Scenario 6: assert reset_n=0 between clock edges while in WARN -> all outputs 0 before the next edge.
